// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the fixed-point sequential divider.
package div_pkg;

    localparam int unsigned W_DEF    = 10;
    localparam int unsigned FRAC_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold N.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_fx_if.sv
// start/busy/valid handshake bundle for seq_divider_fx; rout exists only when DIV_REM_EN is defined.
interface seq_divider_fx_if #(
    parameter int unsigned W = div_pkg::W_DEF
);
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] qout;
    logic         dvz;
    logic         ovf;
    logic         busy;
    logic         valid;
`ifdef DIV_REM_EN
    logic [W-1:0] rout;
`endif

    modport master (
        output start, a_in, b_in,
        input  qout, dvz, ovf, busy, valid
`ifdef DIV_REM_EN
        , input rout
`endif
    );

    modport slave (
        input  start, a_in, b_in,
        output qout, dvz, ovf, busy, valid
`ifdef DIV_REM_EN
        , output rout
`endif
    );
endinterface

// File: rtl/div_datapath.sv
// Restoring-division datapath: ACC/Q/B registers, W+1-bit trial subtract, iteration counter.
// The remainder output exists only when DIV_REM_EN is defined.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic                step,
    input  logic [W-1:0]        a_in,
    input  logic [W-1:0]        b_in,
    output logic [W+FRAC-1:0]   q_c,
`ifdef DIV_REM_EN
    output logic [W-1:0]        rem_c,
`endif
    output logic                co
);
    localparam int unsigned N     = W + FRAC;
    localparam int unsigned ACC_W = W + 1;
    localparam int unsigned SH_W  = W + 2;
    localparam int unsigned CW    = cnt_width(N);

    logic [ACC_W-1:0] acc_q, acc_d, acc_c;
    logic [N-1:0]     q_q, q_d;
    logic [W-1:0]     b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SH_W-1:0]  sh;
    logic             ge;

    // One restoring step: shift {ACC,Q} left, keep the difference only if it is non-negative.
    always_comb begin
        sh    = {acc_q, q_q[N-1]};
        ge    = (sh >= {2'b00, b_q});
        acc_c = ge ? ACC_W'(sh - {2'b00, b_q}) : sh[ACC_W-1:0];
        q_c   = (q_q << 1) | N'(ge);
        co    = (cnt_q == CW'(N - 1));
    end

`ifdef DIV_REM_EN
    assign rem_c = acc_c[W-1:0];
`endif

    always_comb begin
        acc_d = acc_q;
        q_d   = q_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            q_d   = '0;
            b_d   = '0;
            cnt_d = '0;
        end else if (load) begin
            acc_d = '0;
            q_d   = N'(a_in) << FRAC;
            b_d   = b_in;
            cnt_d = '0;
        end else if (step) begin
            acc_d = acc_c;
            q_d   = q_c;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            q_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_divider_fx.sv
// Fixed-point sequential divider: qout = (a_in << FRAC) / b_in with ovf/dvz flags.
// Define DIV_REM_EN to add the registered remainder output rout.
module seq_divider_fx
    import div_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    seq_divider_fx_if.slave  bus
);
    localparam int unsigned N = W + FRAC;

    state_t       state_q, state_d;
    logic [W-1:0] qout_q, qout_d;
    logic         dvz_q, dvz_d;
    logic         ovf_q, ovf_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic         load, step, co, ovf_c;
    logic [N-1:0] q_c;
`ifdef DIV_REM_EN
    logic [W-1:0] rout_q, rout_d, rem_c;
`endif

    div_datapath #(.W(W), .FRAC(FRAC)) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sclr),
        .load  (load),
        .step  (step),
        .a_in  (bus.a_in),
        .b_in  (bus.b_in),
        .q_c   (q_c),
`ifdef DIV_REM_EN
        .rem_c (rem_c),
`endif
        .co    (co)
    );

    // Any quotient bit above the W-bit window is an overflow; an integer divider cannot overflow.
    if (FRAC == 0) begin : g_no_frac
        assign ovf_c = 1'b0;
    end else begin : g_frac
        assign ovf_c = |q_c[N-1:W];
    end

    always_comb begin
        state_d = state_q;
        qout_d  = qout_q;
        dvz_d   = dvz_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
`ifdef DIV_REM_EN
        rout_d  = rout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    qout_d = '0;
                    ovf_d  = 1'b0;
                    dvz_d  = 1'b0;
`ifdef DIV_REM_EN
                    rout_d = '0;
`endif
                    if (bus.b_in == '0) begin
                        dvz_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        load    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                step = 1'b1;
                if (co) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    ovf_d   = ovf_c;
                    qout_d  = ovf_c ? '1 : q_c[W-1:0];
`ifdef DIV_REM_EN
                    rout_d  = rem_c;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Synchronous clear aborts any operation exactly like reset.
        if (sclr) begin
            state_d = IDLE;
            qout_d  = '0;
            dvz_d   = 1'b0;
            ovf_d   = 1'b0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            load    = 1'b0;
            step    = 1'b0;
`ifdef DIV_REM_EN
            rout_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qout_q  <= '0;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef DIV_REM_EN
            rout_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            qout_q  <= qout_d;
            dvz_q   <= dvz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
`ifdef DIV_REM_EN
            rout_q  <= rout_d;
`endif
        end
    end

    assign bus.qout  = qout_q;
    assign bus.dvz   = dvz_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
`ifdef DIV_REM_EN
    assign bus.rout  = rout_q;
`endif

endmodule

// File: tb/tb_seq_divider_fx.sv
// Scoreboard bench for seq_divider_fx: arithmetic reference model, decoupled monitor.
module tb_seq_divider_fx;
    localparam int W    = 10;
    localparam int FRAC = 5;
    localparam int N    = W + FRAC;

    typedef struct {
        logic [W-1:0] q;
        logic         dvz;
        logic         ovf;
        logic [W-1:0] r;
        int           lat;
        int           bsy;
        int           acc_cyc;
    } exp_t;

    logic clk, rst_n, sclr;
    int   cyc;
    int   n_chk, n_fail;
    int   bcnt;
    exp_t sb[$];
    exp_t last;

    seq_divider_fx_if #(.W(W)) bus ();

    seq_divider_fx #(.W(W), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (sclr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer division of the scaled dividend.
    function automatic exp_t model(input int a, input int b, input int acc_cyc);
        exp_t        e;
        logic [63:0] num, quo;
        num       = 64'(a) << FRAC;
        e.acc_cyc = acc_cyc;
        if (b == 0) begin
            e.q = '0; e.dvz = 1'b1; e.ovf = 1'b0; e.r = '0; e.lat = 0; e.bsy = 0;
        end else begin
            quo   = num / 64'(b);
            e.dvz = 1'b0;
            e.ovf = (quo >= (64'd1 << W));
            e.q   = e.ovf ? {W{1'b1}} : quo[W-1:0];
            e.r   = W'(num % 64'(b));
            e.lat = N;
            e.bsy = N;
        end
        return e;
    endfunction

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || sclr) begin
            bcnt = 0;
        end else begin
            if (bus.busy) bcnt++;
            if (bus.valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 64'(bus.valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("qout", 64'(bus.qout), 64'(e.q));
                    check("dvz", 64'(bus.dvz), 64'(e.dvz));
                    check("ovf", 64'(bus.ovf), 64'(e.ovf));
                    check("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    check("busy_cycles", 64'(bcnt), 64'(e.bsy));
`ifdef DIV_REM_EN
                    check("rout", 64'(bus.rout), 64'(e.r));
`endif
                end
                bcnt = 0;
            end
        end
    end

    task automatic push(input int a, input int b);
        last = model(a, b, cyc);
        sb.push_back(last);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * N && !seen; i++) begin
            @(negedge clk);
            if (bus.valid) seen = 1'b1;
        end
        if (!seen) check("valid_timeout", 64'd0, 64'd1);
    endtask

    // Single operation from IDLE, then confirm the result is held once back in IDLE.
    task automatic run_op(input int a, input int b);
        bus.start = 1'b1; bus.a_in = W'(a); bus.b_in = W'(b);
        @(posedge clk); #1;
        push(a, b);
        bus.start = 1'b0;
        wait_valid();
        @(negedge clk);
        check("qout_hold", 64'(bus.qout), 64'(last.q));
        check("valid_pulse", 64'(bus.valid), 64'd0);
        @(posedge clk); #1;
    endtask

    // start held through CALC and DONE; second operands change while the first is iterating.
    task automatic run_b2b(input int a1, input int b1, input int a2, input int b2);
        bus.start = 1'b1; bus.a_in = W'(a1); bus.b_in = W'(b1);
        @(posedge clk); #1;
        push(a1, b1);
        bus.a_in = W'(a2); bus.b_in = W'(b2);
        wait_valid();
        @(posedge clk); #1;
        push(a2, b2);
        bus.start = 1'b0;
        wait_valid();
        @(posedge clk); #1;
    endtask

    task automatic outs_zero(input string name);
        check(name, 64'({bus.qout, bus.dvz, bus.ovf, bus.busy, bus.valid}), 64'd0);
`ifdef DIV_REM_EN
        check({name, "_rout"}, 64'(bus.rout), 64'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; sclr = 1'b0;
        bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
        n_chk = 0; n_fail = 0; bcnt = 0;
        repeat (3) @(posedge clk);
        #1;
        outs_zero("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(6, 4);
        run_op(1023, 1);
        run_op(5, 0);
        run_op(7, 3);
        run_op(1023, 1023);
        run_op(0, 5);
        run_op(1, 1023);
        run_op(31, 1);
        run_op(32, 1);
        run_b2b(100, 7, 9, 3);
        run_b2b(5, 0, 9, 3);
        run_b2b(200, 13, 4, 0);

        // Asynchronous reset in the middle of CALC.
        bus.start = 1'b1; bus.a_in = W'(500); bus.b_in = W'(3);
        @(posedge clk); #1;
        push(500, 3);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("busy_before_rst", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        outs_zero("async_rst_outs");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2 * N) @(posedge clk);
        #1;
        run_op(6, 4);

        // Synchronous clear in the middle of CALC.
        bus.start = 1'b1; bus.a_in = W'(321); bus.b_in = W'(17);
        @(posedge clk); #1;
        push(321, 17);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        sclr = 1'b1;
        check("busy_before_sclr", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        outs_zero("sclr_outs");
        sclr = 1'b0;
        sb.delete();
        repeat (2 * N) @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            int a1, b1, a2, b2;
            a1 = int'($urandom_range(0, 1023));
            b1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
            a2 = int'($urandom_range(0, 1023));
            b2 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
            if ($urandom_range(0, 3) == 0) run_b2b(a1, b1, a2, b2);
            else                           run_op(a1, b1);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

endmodule

// File: doc/seq_divider_fx.md
Name: seq_divider_fx

Overview:
- Parametrised successor of the 10-bit sequential divider: unsigned radix-2 restoring divider computing quotient = (a_in << FRAC) / b_in.
- Output is truncated to W bits, with overflow and divide-by-zero flags.
- Controller FSM plus datapath (ACC/Q/B registers, iteration counter).
- Sits on the same start/busy/valid handshake as the earlier divider; drop-in for the datapath consumers.

Parameters:
- W, 10, operand and quotient width in bits.
- FRAC, 5, number of fractional quotient bits (0 gives an integer divider); N = W+FRAC iterations.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear, active high; same effect as reset, on the next clk edge.
- start  in  1  request; sampled only when the FSM is in IDLE or DONE.
- a_in  in  W  dividend, unsigned.
- b_in  in  W  divisor, unsigned.
- qout  out  W  quotient: Q[W-1:0], or all-ones when ovf=1.
- dvz  out  1  divide-by-zero flag; held until the next accepted start.
- ovf  out  1  quotient exceeds W bits; held until the next accepted start.
- busy  out  1  high while iterating (CALC).
- valid  out  1  one-cycle pulse when the result is ready.

Behaviour:
- Reset (rst_n=0, async) or sclr=1 (sync):
  - state=IDLE.
  - qout=0, dvz=0, ovf=0, busy=0, valid=0.
  - ACC=0, Q=0, B=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE or DONE with start=1, at edge k:
  - a_in and b_in are latched.
  - dvz, ovf and qout are cleared.
  - If b_in==0: go to DONE with dvz=1, qout=0, ovf=0. valid is high in cycle k+1.
  - Otherwise: ACC=0 (W+1 bits), Q={a_in, FRAC'b0} (N bits), B=b_in, counter=0, go to CALC.
- CALC, each edge:
  - Shift {ACC,Q} left by 1.
  - Compute D = ACC_shifted - {1'b0,B}.
  - If D ≥ 0: ACC=D, Q[0]=1. Otherwise ACC is kept and Q[0]=0.
  - counter += 1.
  - At counter==N-1 the FSM goes to DONE, and qout and ovf are latched from the final Q.
- Latency: valid is high in the cycle after the Nth CALC edge, i.e. N+1 cycles after the start-accepting edge. busy is high for exactly N cycles.
- DONE:
  - valid=1 and busy=0.
  - Next edge goes to IDLE, unless start=1, which begins a new operation back-to-back.
- ovf = |Q[N-1:W] (any integer bit above W). When ovf=1, qout saturates to {W{1'b1}}.
- start while in CALC is ignored; operands are not re-sampled.
- Reset or sclr in mid-CALC aborts immediately: no valid is produced and all outputs are cleared.
- Widths:
  - counter is $clog2(N+1) bits.
  - Subtraction uses W+1 bits, so there is no lost carry.
  - FRAC=0 must elaborate, with no zero-width slices.

Optional Feature:
- DIV_REM_EN:
  - Defined: adds output rout (W bits) = ACC[W-1:0] at DONE, the remainder of (a<<FRAC)/b. rout=0 on dvz and on reset; it is held like qout.
  - Undefined: no rout port and no remainder register; ACC is internal only.

Decomposition:
- Package div_pkg:
  - State enum {IDLE, CALC, DONE}.
  - Default W and FRAC localparams.
  - Function for the counter width.
- Sub-module div_datapath: ACC/Q/B registers, subtractor, counter, co (counter terminal) flag.
- Top seq_divider_fx contains the FSM and output registers.

Test Plan:
- W=10, FRAC=5; a=6, b=4, start at edge 0 -> busy for 15 cycles; valid at cycle 16; qout=48 (1.5×32); ovf=0; dvz=0.
- a=1023, b=1 -> ovf=1, qout=0x3FF, valid after 16 cycles.
- a=5, b=0 -> dvz=1, qout=0, busy never high, valid in cycle 1.
- Back-to-back: start held high during DONE with a=9, b=3 -> new operation starts with no IDLE cycle; qout=96.
- rst_n low asynchronously mid-CALC (cycle 7) -> all outputs 0 immediately; no valid. sclr likewise on the next edge.
- DIV_REM_EN build, a=7, b=3 -> qout=74, rout=2, since (7<<5)=224=3×74+2.
